demux_pipeline: RTL and testbench
=================================

Name: demux_pipeline

Overview:
- Pipelined 1:N demultiplexer; routes one WIDTH-bit sample to one of OUTPUT_COUNT lanes with a fixed LATENCY.
- Counterpart of the pipelined N:1 mux in the toolbox: fans data out to per-channel consumers (e.g. FIFOs, per-port registers), where the mux gathers it in.
- The routing tree splits the select field across LATENCY register stages, so no stage decodes more than ceil(SEL_W/LATENCY) select bits.
- Throughput is one sample per clock; there is no backpressure.

Parameters:
- WIDTH, 1, data bits per sample and per output lane.
- OUTPUT_COUNT, 2, number of output lanes; must be >= 2; need not be a power of two.
- LATENCY, 1, register stages from input to output; must be >= 1.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  qualifies `in` and `sel` this cycle.
- sel  input  SEL_W = $clog2(OUTPUT_COUNT)  destination lane index.
- in  input  WIDTH  sample data.
- out  output  WIDTH*OUTPUT_COUNT  lane i occupies out[i*WIDTH+:WIDTH].
- out_valid  output  OUTPUT_COUNT  one-hot (or zero) per-lane strobe.

Behaviour:
- Reset:
  - out = 0, out_valid = 0.
  - All internal valid, select and data stage registers cleared.
  - In-flight samples are discarded.
  - in_valid is ignored while rst is high.
- Acceptance: every cycle with in_valid=1 and rst=0 accepts a sample; no ready signal.
- Latency: a sample accepted at edge T with sel=k gives out_valid[k]=1 for exactly one cycle after edge T+LATENCY. out[k] shows the sample from that same edge.
- Lane hold: each out lane is a register loaded only when its strobe fires. It holds its last delivered value otherwise; unselected lanes never change.
- Stage split:
  - BITS_PER_STAGE = ceil(SEL_W/LATENCY).
  - Stage s (s=0 first) decodes sel bits from the MSB downward, consuming BITS_PER_STAGE bits per stage, and enables one branch register group.
  - Undecoded sel bits travel with the data.
  - Stages beyond SEL_W bits act as pure delay registers (valid, data and sel shift with no decode).
- Back-to-back: samples on consecutive cycles to the same or different lanes are all delivered, in order, one per cycle. No sample is dropped or merged.
- Out-of-range select: when sel >= OUTPUT_COUNT (non-power-of-two counts), the sample propagates but no out_valid bit fires and no lane updates.
- Idle: in_valid=0 gives out_valid=0 LATENCY cycles later; lanes hold.
- Reset mid-operation: rst asserted at edge T clears everything at T. Samples accepted before T never appear. The first sample accepted after rst deasserts emerges at normal LATENCY.
- Invariant: popcount(out_valid) <= 1 every cycle.

Optional Feature:
- Macro: DEMUX_PIPELINE_SEL_CHECK_EN.
- With it defined:
  - Adds output port err_oob (1 bit, reset 0).
  - err_oob is sticky: set at the cycle an out-of-range sample reaches the output stage (same timing as out_valid would have been).
  - Cleared only by rst.
- Without it:
  - Port absent.
  - Out-of-range samples are silently dropped as described above.
  - No extra logic.

Test Plan (WIDTH=4, OUTPUT_COUNT=10, LATENCY=2 unless noted):
- Reset: hold rst 3 cycles with in_valid=1, in=4'hF, sel=3 -> out=0 and out_valid=0 throughout and for 2 cycles after release.
- Single sample: in=4'hA, sel=7, in_valid pulse at edge T -> out_valid=10'b0010000000 one cycle after edge T+2; out[28+:4]=4'hA and held; all other lanes unchanged.
- Sweep: sel=0..9 on consecutive cycles, in=sel -> out_valid walks bit 0..9 one per cycle starting 2 cycles later; finally out[i*4+:4]=i for all i.
- Out-of-range: sel=12, in=4'h5 -> out_valid stays 0, lanes unchanged; with DEMUX_PIPELINE_SEL_CHECK_EN, err_oob rises 2 cycles later and stays 1 until rst.
- Mid-flight reset: send sel=2 at T and sel=4 at T+1, assert rst at T+1 for 1 cycle -> neither lane 2 nor lane 4 strobes; next sample sel=4 at T+3 strobes after edge T+5.
- Latency variants: LATENCY=1 and LATENCY=6 (delay-only stages), sel=9, in=4'h3 -> single strobe on lane 9 exactly LATENCY cycles after acceptance.

Source files
------------

// File: rtl/demux_pipeline_if.sv
// rtl/demux_pipeline_if.sv - sample/select input and lane output bundle for demux_pipeline (err_oob present only with DEMUX_PIPELINE_SEL_CHECK_EN)
interface demux_pipeline_if #(
  parameter int WIDTH        = 1,
  parameter int OUTPUT_COUNT = 2
);
  localparam int SEL_W = $clog2(OUTPUT_COUNT);

  logic                          in_valid;
  logic [SEL_W-1:0]              sel;
  logic [WIDTH-1:0]              in;
  logic [WIDTH*OUTPUT_COUNT-1:0] out;
  logic [OUTPUT_COUNT-1:0]       out_valid;
`ifdef DEMUX_PIPELINE_SEL_CHECK_EN
  logic                          err_oob;
`endif

  // Producer side: drives the sample, consumes the lanes.
  modport master (
    output in_valid, sel, in,
`ifdef DEMUX_PIPELINE_SEL_CHECK_EN
    input  err_oob,
`endif
    input  out, out_valid
  );

  // Demux side.
  modport slave (
    input  in_valid, sel, in,
`ifdef DEMUX_PIPELINE_SEL_CHECK_EN
    output err_oob,
`endif
    output out, out_valid
  );
endinterface

// File: rtl/demux_pipeline.sv
// rtl/demux_pipeline.sv - pipelined 1:N demux, select decoded MSB-first across LATENCY stages; optional sticky err_oob via DEMUX_PIPELINE_SEL_CHECK_EN
module demux_pipeline #(
  parameter int WIDTH        = 1,
  parameter int OUTPUT_COUNT = 2,
  parameter int LATENCY      = 1
) (
  input logic              clk,
  input logic              rst,
  demux_pipeline_if.slave  bus
);
  localparam int SEL_W = $clog2(OUTPUT_COUNT);
  localparam int BPS   = (SEL_W + LATENCY - 1) / LATENCY;
  localparam int NBR   = 1 << SEL_W;

  // Per-stage inputs: st_grp[s] is a one-hot branch enable indexed by the
  // select prefix decoded so far (all zero means no sample in that slot).
  logic [NBR-1:0]   st_grp [LATENCY];
  logic [SEL_W-1:0] st_sel [LATENCY];
  logic [WIDTH-1:0] st_dat [LATENCY];

  logic [NBR-1:0]   fin_grp;
  logic [WIDTH-1:0] fin_dat;

  assign st_grp[0] = NBR'(bus.in_valid);
  assign st_sel[0] = bus.sel;
  assign st_dat[0] = bus.in;

  for (genvar s = 0; s < LATENCY; s++) begin : g_stage
    localparam int PRE  = (s * BPS < SEL_W) ? s * BPS : SEL_W;
    localparam int POST = ((s + 1) * BPS < SEL_W) ? (s + 1) * BPS : SEL_W;
    localparam int NB   = POST - PRE;
    localparam logic [31:0] MASK = (32'd1 << NB) - 32'd1;

    logic [31:0]    chunk;
    logic [NBR-1:0] grp_d;

    // The NB select bits this stage owns; zero-width for delay-only stages.
    assign chunk = (32'(st_sel[s]) >> (SEL_W - POST)) & MASK;

    // Split each parent branch into 2^NB children, enabling the one matching chunk.
    always_comb begin
      grp_d = '0;
      for (int p = 0; p < NBR; p++) begin
        grp_d[SEL_W'(p)] = st_grp[s][SEL_W'(p >> NB)] & (chunk == (32'(p) & MASK));
      end
    end

    if (s < LATENCY - 1) begin : g_reg
      logic [NBR-1:0]   grp_q;
      logic [SEL_W-1:0] sel_q, sel_d;
      logic [WIDTH-1:0] dat_q, dat_d;

      // Undecoded select bits and data ride along with the branch enable.
      always_comb begin
        sel_d = st_sel[s];
        dat_d = st_dat[s];
      end

      // Stage register; reset drops any in-flight sample.
      always_ff @(posedge clk) begin
        if (rst) begin
          grp_q <= '0;
          sel_q <= '0;
          dat_q <= '0;
        end else begin
          grp_q <= grp_d;
          sel_q <= sel_d;
          dat_q <= dat_d;
        end
      end

      assign st_grp[s+1] = grp_q;
      assign st_sel[s+1] = sel_q;
      assign st_dat[s+1] = dat_q;
    end else begin : g_last
      assign fin_grp = grp_d;
      assign fin_dat = st_dat[s];
    end
  end

  logic [WIDTH*OUTPUT_COUNT-1:0] out_q, out_d;
  logic [OUTPUT_COUNT-1:0]       out_valid_q, out_valid_d;

  // Final stage: strobe the decoded lane and load only that lane; branches
  // past OUTPUT_COUNT have no lane, so out-of-range samples vanish here.
  always_comb begin
    out_d       = out_q;
    out_valid_d = fin_grp[OUTPUT_COUNT-1:0];
    for (int i = 0; i < OUTPUT_COUNT; i++) begin
      if (fin_grp[SEL_W'(i)]) out_d[i*WIDTH +: WIDTH] = fin_dat;
    end
  end

  // Lane and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

`ifdef DEMUX_PIPELINE_SEL_CHECK_EN
  logic err_oob_q, err_oob_d;

  // Sticky flag: any sample arriving on a branch with no lane behind it.
  always_comb begin
    err_oob_d = err_oob_q;
    for (int p = OUTPUT_COUNT; p < NBR; p++) begin
      err_oob_d = err_oob_d | fin_grp[SEL_W'(p)];
    end
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) err_oob_q <= 1'b0;
    else     err_oob_q <= err_oob_d;
  end

  assign bus.err_oob = err_oob_q;
`endif
endmodule

// File: tb/tb_demux_pipeline.sv
// tb/tb_demux_pipeline.sv - directed self-checking bench for demux_pipeline (LATENCY 2, 1 and 6)
module tb_demux_pipeline;
  logic clk;
  logic rst;

  int vectors;
  int miscompares;

  demux_pipeline_if #(.WIDTH(4), .OUTPUT_COUNT(10)) bus2 ();
  demux_pipeline_if #(.WIDTH(4), .OUTPUT_COUNT(10)) bus1 ();
  demux_pipeline_if #(.WIDTH(4), .OUTPUT_COUNT(10)) bus6 ();

  demux_pipeline #(.WIDTH(4), .OUTPUT_COUNT(10), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  demux_pipeline #(.WIDTH(4), .OUTPUT_COUNT(10), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  demux_pipeline #(.WIDTH(4), .OUTPUT_COUNT(10), .LATENCY(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [39:0] exp_out;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    bus2.in_valid = 1'b1; bus2.in = 4'hF; bus2.sel = 4'd3;
    bus1.in_valid = 1'b0; bus1.in = 4'h0; bus1.sel = 4'd0;
    bus6.in_valid = 1'b0; bus6.in = 4'h0; bus6.sel = 4'd0;

    // Reset held 3 cycles with in_valid asserted
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_out", bus2.out, 40'h0);
      chk("rst_vld", bus2.out_valid, 10'h0);
    end
    rst = 1'b0;
    bus2.in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("post_rst_out", bus2.out, 40'h0);
      chk("post_rst_vld", bus2.out_valid, 10'h0);
    end
`ifdef DEMUX_PIPELINE_SEL_CHECK_EN
    chk("rst_err", bus2.err_oob, 1'b0);
`endif
    chk("rst_vld_l1", bus1.out_valid, 10'h0);
    chk("rst_vld_l6", bus6.out_valid, 10'h0);

    // Single sample to lane 7
    exp_out = 40'h0;
    bus2.in_valid = 1'b1; bus2.in = 4'hA; bus2.sel = 4'd7;
    tick();
    bus2.in_valid = 1'b0;
    chk("single_early", bus2.out_valid, 10'h0);
    tick();
    exp_out[28 +: 4] = 4'hA;
    chk("single_vld", bus2.out_valid, 10'b0010000000);
    chk("single_out", bus2.out, exp_out);
    tick();
    chk("single_drop", bus2.out_valid, 10'h0);
    chk("single_hold", bus2.out, exp_out);

    // Sweep lanes 0..9 back to back
    for (int c = 0; c < 12; c++) begin
      if (c < 10) begin
        bus2.in_valid = 1'b1; bus2.in = 4'(c); bus2.sel = 4'(c);
      end else begin
        bus2.in_valid = 1'b0;
      end
      tick();
      if (c >= 1) chk("sweep_vld", bus2.out_valid, (c - 1 < 10) ? (64'd1 << (c - 1)) : 64'd0);
    end
    exp_out = 40'h9876543210;
    chk("sweep_out", bus2.out, exp_out);

    // Back-to-back to the same lane
    bus2.in_valid = 1'b1; bus2.in = 4'h1; bus2.sel = 4'd3;
    tick();
    bus2.in = 4'h2;
    tick();
    bus2.in_valid = 1'b0;
    exp_out[12 +: 4] = 4'h1;
    chk("b2b_vld0", bus2.out_valid, 10'b0000001000);
    chk("b2b_out0", bus2.out, exp_out);
    tick();
    exp_out[12 +: 4] = 4'h2;
    chk("b2b_vld1", bus2.out_valid, 10'b0000001000);
    chk("b2b_out1", bus2.out, exp_out);
    tick();
    chk("b2b_idle", bus2.out_valid, 10'h0);

    // Out-of-range select
    bus2.in_valid = 1'b1; bus2.in = 4'h5; bus2.sel = 4'd12;
    tick();
    bus2.in_valid = 1'b0;
    chk("oob_vld0", bus2.out_valid, 10'h0);
`ifdef DEMUX_PIPELINE_SEL_CHECK_EN
    chk("oob_err_early", bus2.err_oob, 1'b0);
`endif
    tick();
    chk("oob_vld1", bus2.out_valid, 10'h0);
    chk("oob_out", bus2.out, exp_out);
`ifdef DEMUX_PIPELINE_SEL_CHECK_EN
    chk("oob_err_set", bus2.err_oob, 1'b1);
`endif
    tick();
    chk("oob_vld2", bus2.out_valid, 10'h0);
`ifdef DEMUX_PIPELINE_SEL_CHECK_EN
    chk("oob_err_sticky", bus2.err_oob, 1'b1);
`endif

    // Mid-flight reset
    bus2.in_valid = 1'b1; bus2.in = 4'h6; bus2.sel = 4'd2;
    tick();
    bus2.in = 4'h7; bus2.sel = 4'd4;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus2.in_valid = 1'b0;
    exp_out = 40'h0;
    chk("mid_rst_vld", bus2.out_valid, 10'h0);
    chk("mid_rst_out", bus2.out, exp_out);
`ifdef DEMUX_PIPELINE_SEL_CHECK_EN
    chk("mid_rst_err", bus2.err_oob, 1'b0);
`endif
    tick();
    chk("mid_rst_vld2", bus2.out_valid, 10'h0);
    bus2.in_valid = 1'b1; bus2.in = 4'h9; bus2.sel = 4'd4;
    tick();
    bus2.in_valid = 1'b0;
    chk("after_rst_early", bus2.out_valid, 10'h0);
    tick();
    exp_out[16 +: 4] = 4'h9;
    chk("after_rst_vld", bus2.out_valid, 10'b0000010000);
    chk("after_rst_out", bus2.out, exp_out);

    // Latency variants: LATENCY=1 and LATENCY=6 to lane 9
    bus1.in_valid = 1'b1; bus1.in = 4'h3; bus1.sel = 4'd9;
    bus6.in_valid = 1'b1; bus6.in = 4'h3; bus6.sel = 4'd9;
    for (int k = 1; k <= 7; k++) begin
      tick();
      bus1.in_valid = 1'b0;
      bus6.in_valid = 1'b0;
      chk("lat1_vld", bus1.out_valid, (k == 1) ? 64'h200 : 64'h0);
      chk("lat6_vld", bus6.out_valid, (k == 6) ? 64'h200 : 64'h0);
    end
    chk("lat1_out", bus1.out, 40'h3000000000);
    chk("lat6_out", bus6.out, 40'h3000000000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
